// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_pkg
// Description : Shared MAC datapath constants and the RX FIFO entry type.
//               An RX FIFO entry is one received byte plus an end-of-frame
//               flag, so the host side can recover frame boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

  localparam int MAC_BYTE_W     = 8;
  localparam int RX_FIFO_DEPTH  = 128;
  localparam int RX_FIFO_ADDR_W = $clog2(RX_FIFO_DEPTH);

  // 9-bit FIFO entry {eof, byte}
  typedef struct packed {
    logic                  eof;
    logic [MAC_BYTE_W-1:0] data;
  } rx_entry_t;

endpackage : mac_pkg
`default_nettype wire

// File: rtl/mac_rx_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : mac_rx_fifo_ram
// Description : Simple dual-port DEPTH x 9 storage for the RX frame FIFO.
//               Synchronous write port; read port with a registered output
//               that holds its value when no read is requested.
// Ports       : clk, rst_n          - clock, async active-low reset
//               wr_en_i/wr_addr_i/wr_entry_i - write port
//               rd_en_i/rd_addr_i   - read request and address
//               rd_entry_o          - registered read data {eof, byte}
//               rd_eof_peek_o       - eof flag of the entry at rd_addr_i,
//                                     visible before it is popped
// Revision    : 1.0 - initial release
// ============================================================================
module mac_rx_fifo_ram
  import mac_pkg::*;
#(
  parameter int DEPTH  = RX_FIFO_DEPTH,
  parameter int ADDR_W = RX_FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  rx_entry_t         wr_entry_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output rx_entry_t         rd_entry_o,
  output logic              rd_eof_peek_o
);

  rx_entry_t mem_q [DEPTH];
  rx_entry_t rd_q;

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_entry_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else if (rd_en_i) begin
      rd_q <= mem_q[rd_addr_i];
    end
  end

  // The frame counter must know at pop time whether the popped byte ends
  // a frame, so the eof flag is also read combinationally.
  assign rd_eof_peek_o = mem_q[rd_addr_i].eof;
  assign rd_entry_o    = rd_q;

endmodule : mac_rx_fifo_ram
`default_nettype wire

// File: rtl/mac_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mac_rx_fifo
// Description : Receive-side frame FIFO. Bytes are written speculatively and
//               become readable only when the frame's last byte arrives with
//               a good status; bad or overflowed frames are rewound and
//               counted as dropped.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               rx_fifo_wr_*_i, rx_frame_good_i - deframer write side
//               rx_fifo_rd_en_i             - host pop request
//               rx_fifo_rd_data/valid/last_o - popped byte (1-cycle latency)
//               rx_fifo_empty_o/full_o      - occupancy flags
//               rx_frame_avail_o            - a complete frame is stored
//               rx_drop_cnt_o               - saturating dropped-frame count
// Revision    : 1.0 - initial release
// ============================================================================
module mac_rx_fifo
  import mac_pkg::*;
#(
  parameter int DEPTH  = RX_FIFO_DEPTH,
  parameter int ADDR_W = RX_FIFO_ADDR_W,
  parameter int DROP_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [MAC_BYTE_W-1:0] rx_fifo_wr_data_i,
  input  logic                  rx_fifo_wr_en_i,
  input  logic                  rx_fifo_wr_last_i,
  input  logic                  rx_frame_good_i,
  input  logic                  rx_fifo_rd_en_i,
  output logic [MAC_BYTE_W-1:0] rx_fifo_rd_data_o,
  output logic                  rx_fifo_rd_valid_o,
  output logic                  rx_fifo_rd_last_o,
  output logic                  rx_fifo_empty_o,
  output logic                  rx_fifo_full_o,
  output logic                  rx_frame_avail_o,
  output logic [DROP_W-1:0]     rx_drop_cnt_o
);

  localparam logic [ADDR_W:0] c_full_used = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] c_ptr_one   = (ADDR_W+1)'(1);

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   commit_ptr_q, commit_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   frame_cnt_q, frame_cnt_d;
  logic              ovf_q, ovf_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [ADDR_W:0]   w_used;
  logic              w_full, w_empty;
  logic              w_do_wr, w_eof, w_commit, w_drop;
  logic              w_do_rd, w_peek_eof, w_pop_last;
  rx_entry_t         w_wr_entry, w_rd_entry;

  // The extra pointer MSB separates full (used==DEPTH) from empty.
  assign w_used  = wr_ptr_q - rd_ptr_q;
  assign w_full  = (w_used == c_full_used);
  assign w_empty = (rd_ptr_q == commit_ptr_q);

  assign w_do_wr    = rx_fifo_wr_en_i & ~w_full;
  assign w_eof      = rx_fifo_wr_en_i & rx_fifo_wr_last_i;
  // A last byte arriving while full is itself lost, so the frame is dropped.
  assign w_commit   = w_eof & rx_frame_good_i & ~ovf_q & ~w_full;
  assign w_drop     = w_eof & ~w_commit;
  assign w_do_rd    = rx_fifo_rd_en_i & ~w_empty;
  assign w_pop_last = w_do_rd & w_peek_eof;

  assign w_wr_entry = '{eof: rx_fifo_wr_last_i, data: rx_fifo_wr_data_i};

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    frame_cnt_d  = frame_cnt_q;
    ovf_d        = ovf_q;
    drop_cnt_d   = drop_cnt_q;
    rd_valid_d   = w_do_rd;

    if (w_do_wr) begin
      wr_ptr_d = wr_ptr_q + c_ptr_one;
    end else if (rx_fifo_wr_en_i) begin
      ovf_d = 1'b1;
    end

    if (w_commit) begin
      commit_ptr_d = wr_ptr_q + c_ptr_one;
    end else if (w_drop) begin
      wr_ptr_d = commit_ptr_q;
      ovf_d    = 1'b0;
      if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end
    end

    if (w_do_rd) begin
      rd_ptr_d = rd_ptr_q + c_ptr_one;
    end

    case ({w_commit, w_pop_last})
      2'b10:   frame_cnt_d = frame_cnt_q + c_ptr_one;
      2'b01:   frame_cnt_d = frame_cnt_q - c_ptr_one;
      default: frame_cnt_d = frame_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      frame_cnt_q  <= '0;
      ovf_q        <= 1'b0;
      rd_valid_q   <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      frame_cnt_q  <= frame_cnt_d;
      ovf_q        <= ovf_d;
      rd_valid_q   <= rd_valid_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  mac_rx_fifo_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en_i       (w_do_wr),
    .wr_addr_i     (wr_ptr_q[ADDR_W-1:0]),
    .wr_entry_i    (w_wr_entry),
    .rd_en_i       (w_do_rd),
    .rd_addr_i     (rd_ptr_q[ADDR_W-1:0]),
    .rd_entry_o    (w_rd_entry),
    .rd_eof_peek_o (w_peek_eof)
  );

  assign rx_fifo_rd_data_o  = w_rd_entry.data;
  assign rx_fifo_rd_last_o  = w_rd_entry.eof;
  assign rx_fifo_rd_valid_o = rd_valid_q;
  assign rx_fifo_empty_o    = w_empty;
  assign rx_fifo_full_o     = w_full;
  assign rx_frame_avail_o   = (frame_cnt_q != '0);
  assign rx_drop_cnt_o      = drop_cnt_q;

endmodule : mac_rx_fifo
`default_nettype wire
